// File: rtl/page_tile_grid_if.sv
// Font ROM bus between the tile renderer and the external glyph ROM.
// master: drives font_addr, samples font_bit; slave: the ROM side.
interface page_tile_grid_if #(
  parameter int FONT_AW = 15
);
  logic [FONT_AW-1:0] font_addr;
  logic               font_bit;

  modport master (output font_addr, input font_bit);
  modport slave  (input font_addr, output font_bit);
endinterface

// File: rtl/page_tile_grid.sv
// Digit-tile renderer: ROWS x MAX_COLS glyph cells centred on 640x480.
// Ports: vga_clk/vga_rst, x_pos/y_pos, frame_start, total_number, status,
// selecting/selected/cur_select, font (ROM bus), pixel_data (12-bit RGB).
module page_tile_grid #(
  parameter int          MAX_COLS     = 5,
  parameter int          ROWS         = 2,
  parameter int          CELL_W       = 80,
  parameter int          CELL_H       = 128,
  parameter int          ROW_Y0       = 86,
  parameter int          ROW_PITCH    = 180,
  parameter int          GLYPH_W      = 32,
  parameter int          GLYPH_H      = 64,
  parameter int          GLYPH_X0     = 8,
  parameter int          SCALE        = 2,
  parameter int          FONT_ROW_W   = 320,
  parameter int          FONT_AW      = 15,
  parameter int          FONT_LAT     = 1,
  parameter int          BORDER       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic                       vga_clk,
  input  logic                       vga_rst,
  input  logic [9:0]                 x_pos,
  input  logic [9:0]                 y_pos,
  input  logic                       frame_start,
  input  logic [3:0]                 total_number,
  input  logic [4*ROWS*MAX_COLS-1:0] status,
  input  logic                       selecting,
  input  logic [3:0]                 selected,
  input  logic [3:0]                 cur_select,
  page_tile_grid_if.master           font,
  output logic [11:0]                pixel_data
);

  localparam int NC = ROWS * MAX_COLS;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {C_BG, C_FRM, C_GLY, C_WHT} cls_e;

  logic [3:0]         r_tot;
  logic [4*NC-1:0]    r_status;
  logic               r_selng;
  logic [3:0]         r_sel;
  logic [3:0]         r_cur;
  logic [BW-1:0]      r_fcnt;
  logic               r_blink;
  logic [FONT_AW-1:0] r_addr;
  logic [11:0]        r_pix;
  cls_e               r_cls [0:FONT_LAT];
  logic               r_grn [0:FONT_LAT];

  logic [3:0]         w_n;
  logic [10:0]        w_left, w_x, w_y;
  logic [10:0]        w_rtop, w_cleft;
  logic [10:0]        w_dx, w_dy, w_gx, w_gy;
  logic               w_rhit, w_chit, w_hit;
  logic               w_glyph, w_edge, w_frame, w_green;
  logic [3:0]         w_row, w_col, w_code;
  logic [7:0]         w_idx;
  logic [FONT_AW-1:0] w_addr;
  cls_e               w_cls;
  logic [11:0]        w_pix;

  // Display state is only taken at frame start so a frame never tears.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      r_tot    <= '0;
      r_status <= '0;
      r_selng  <= 1'b0;
      r_sel    <= '0;
      r_cur    <= '0;
    end else if (frame_start) begin
      r_tot    <= total_number;
      r_status <= status;
      r_selng  <= selecting;
      r_sel    <= selected;
      r_cur    <= cur_select;
    end
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      r_fcnt  <= '0;
      r_blink <= 1'b1;
    end else if (frame_start && BLINK_FRAMES != 0) begin
      if (r_fcnt == BW'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fcnt  <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_n    = (r_tot > 4'(MAX_COLS)) ? 4'(MAX_COLS) : r_tot;
  assign w_left = 11'(320 - int'(w_n) * (CELL_W / 2));
  assign w_x    = {1'b0, x_pos};
  assign w_y    = {1'b0, y_pos};

  always_comb begin
    w_rhit = 1'b0;
    w_row  = '0;
    w_rtop = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_y >= 11'(ROW_Y0 + r * ROW_PITCH) &&
          w_y <  11'(ROW_Y0 + r * ROW_PITCH + CELL_H)) begin
        w_rhit = 1'b1;
        w_row  = 4'(r);
        w_rtop = 11'(ROW_Y0 + r * ROW_PITCH);
      end
    end
  end

  // Column found by comparing against each cell boundary; no divider.
  always_comb begin
    w_chit  = 1'b0;
    w_col   = '0;
    w_cleft = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (4'(c) < w_n &&
          w_x >= w_left + 11'(c * CELL_W) &&
          w_x <  w_left + 11'((c + 1) * CELL_W)) begin
        w_chit  = 1'b1;
        w_col   = 4'(c);
        w_cleft = w_left + 11'(c * CELL_W);
      end
    end
  end

  assign w_idx = 8'(int'(w_row) * MAX_COLS + int'(w_col));

  always_comb begin
    w_code = '0;
    for (int i = 0; i < NC; i++) begin
      if (w_idx == 8'(i)) w_code = r_status[4*i +: 4];
    end
  end

  assign w_hit = w_rhit & w_chit;
  assign w_dx  = w_x - w_cleft;
  assign w_dy  = w_y - w_rtop;

  assign w_glyph = w_hit &&
                   w_dx >= 11'(GLYPH_X0) &&
                   w_dx <  11'(GLYPH_X0 + GLYPH_W * SCALE) &&
                   w_dy <  11'(GLYPH_H * SCALE);

  assign w_gx   = (w_dx - 11'(GLYPH_X0)) / 11'(SCALE);
  assign w_gy   = w_dy / 11'(SCALE);
  assign w_addr = FONT_AW'(int'(w_gy) * FONT_ROW_W +
                           int'(w_code) * GLYPH_W +
                           int'(w_gx));

  assign w_edge = w_dx <  11'(BORDER) ||
                  w_dx >= 11'(CELL_W - BORDER) ||
                  w_dy <  11'(BORDER) ||
                  w_dy >= 11'(CELL_H - BORDER);

  assign w_frame = w_hit && r_blink && w_edge &&
                   ({4'b0, r_cur} == w_idx);
  assign w_green = r_selng && ({4'b0, r_sel} == w_idx);

  // Codes above 9 have no glyph, so they fall through to a blank cell.
  always_comb begin
    w_cls = C_BG;
    if (!w_hit)                         w_cls = C_BG;
    else if (w_frame)                   w_cls = C_FRM;
    else if (w_glyph && w_code <= 4'd9) w_cls = C_GLY;
    else                                w_cls = C_WHT;
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst)      r_addr <= '0;
    else if (w_glyph) r_addr <= w_addr;
  end

  assign font.font_addr = r_addr;

  // Side-band delay line: stage FONT_LAT lines up with font_bit.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      for (int i = 0; i <= FONT_LAT; i++) begin
        r_cls[i] <= C_BG;
        r_grn[i] <= 1'b0;
      end
    end else begin
      r_cls[0] <= w_cls;
      r_grn[0] <= w_green;
      for (int i = 1; i <= FONT_LAT; i++) begin
        r_cls[i] <= r_cls[i-1];
        r_grn[i] <= r_grn[i-1];
      end
    end
  end

  always_comb begin
    w_pix = BG_COLOR;
    unique case (r_cls[FONT_LAT])
      C_BG:  w_pix = BG_COLOR;
      C_FRM: w_pix = 12'h00f;
      C_GLY: w_pix = !font.font_bit    ? 12'hfff :
                     r_grn[FONT_LAT]   ? 12'h0f0 : 12'h000;
      C_WHT: w_pix = 12'hfff;
    endcase
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) r_pix <= '0;
    else         r_pix <= w_pix;
  end

  assign pixel_data = r_pix;

endmodule
